rb_osc_am_mixer: RTL and testbench

- Downstream stage of the RadioBox DDS oscillators.
- Consumes the OSC1 (carrier) and OSC2 (modulator) AXI-stream sample streams and produces an amplitude-modulated sample stream for the DAC/output path: out = car * (ofs + gain*mod).
- 3-stage pipeline with valid/ready back-pressure, enable/drain control FSM and sticky overflow flag; runs on the 125 MHz ADC clock domain.

---
 rtl/rb_osc_am_mixer.sv | 145 ++++++++++++++
 tb/tb_rb_osc_am_mixer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rb_osc_am_mixer.sv
// RadioBox AM mixer: joins the carrier/modulator streams into out = car * (ofs + gain*mod).
// Define RB_AM_MIXER_SAT_EN to saturate on overflow; the default build wraps.
module rb_osc_am_mixer #(
    parameter int DW = 16,
    parameter int GW = 16
) (
    input  logic          clk_adc_125mhz,
    input  logic          adc_rst_i,
    input  logic          en_i,
    input  logic          car_s_vld,
    input  logic [DW-1:0] car_s_data,
    output logic          car_s_rdy,
    input  logic          mod_s_vld,
    input  logic [DW-1:0] mod_s_data,
    output logic          mod_s_rdy,
    input  logic [GW-1:0] gain_i,
    input  logic [GW-1:0] ofs_i,
    output logic          mix_m_vld,
    output logic [DW-1:0] mix_m_data,
    input  logic          mix_m_rdy,
    output logic          ovf_o,
    input  logic          ovf_clr_i,
    output logic          busy_o
);
    localparam int PW = GW + DW + 1;   // gain*mod product
    localparam int SW = PW - GW;       // product after >>> GW
    localparam int EW = GW + 2;        // envelope
    localparam int MW = DW + EW;       // car*env product
    localparam int RW = MW - (GW - 1); // after Q1.15 rescale

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t               r_state;
    logic                 r_busy;
    logic [3:1]           r_vld_pipe;
    logic signed [DW-1:0] r_car1, r_mod1, r_car2;
    logic [GW-1:0]        r_gain1, r_ofs1;
    logic signed [EW-1:0] r_env2;
    logic [DW-1:0]        r_out;
    logic                 r_ovf;

    logic                 w_adv, w_accept, w_fire;
    logic [3:1]           w_vld_nxt;
    logic signed [PW-1:0] w_gain_x, w_mod_x, w_prod;
    logic signed [SW-1:0] w_mterm;
    logic signed [EW-1:0] w_env;
    logic signed [MW-1:0] w_car_x, w_env_x, w_p;
    logic [RW-1:0]        w_r;
    logic                 w_r_ovf;
    logic [DW-1:0]        w_out;

    // Whole pipeline advances together; the join only fires when both streams are valid.
    assign w_adv     = !r_vld_pipe[3] | mix_m_rdy;
    assign w_accept  = (r_state == ST_RUN) & w_adv;
    assign car_s_rdy = w_accept & mod_s_vld;
    assign mod_s_rdy = w_accept & car_s_vld;
    assign w_fire    = w_accept & car_s_vld & mod_s_vld;
    assign w_vld_nxt = w_adv ? {r_vld_pipe[2:1], w_fire} : r_vld_pipe;

    assign w_gain_x = PW'(r_gain1);
    assign w_mod_x  = PW'(r_mod1);
    assign w_prod   = w_gain_x * w_mod_x;
    assign w_mterm  = SW'(w_prod >>> GW);
    assign w_env    = EW'(w_mterm) + EW'(r_ofs1);

    assign w_car_x = MW'(r_car2);
    assign w_env_x = MW'(r_env2);
    assign w_p     = w_car_x * w_env_x;
    assign w_r     = RW'(w_p >>> (GW - 1));
    // In range iff all bits from the DW sign bit upward agree.
    assign w_r_ovf = !((&w_r[RW-1:DW-1]) | !(|w_r[RW-1:DW-1]));

`ifdef RB_AM_MIXER_SAT_EN
    assign w_out = !w_r_ovf    ? w_r[DW-1:0] :
                   w_r[RW-1]   ? {1'b1, {(DW-1){1'b0}}} :
                                 {1'b0, {(DW-1){1'b1}}};
`else
    assign w_out = w_r[DW-1:0];
`endif

    always_ff @(posedge clk_adc_125mhz or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            r_vld_pipe <= '0;
            r_car1     <= '0;
            r_mod1     <= '0;
            r_gain1    <= '0;
            r_ofs1     <= '0;
            r_car2     <= '0;
            r_env2     <= '0;
            r_out      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_vld_pipe <= w_vld_nxt;
            if (w_adv) begin
                if (w_fire) begin
                    r_car1  <= car_s_data;
                    r_mod1  <= mod_s_data;
                    r_gain1 <= gain_i;
                    r_ofs1  <= ofs_i;
                end
                if (r_vld_pipe[1]) begin
                    r_car2 <= r_car1;
                    r_env2 <= w_env;
                end
                if (r_vld_pipe[2]) r_out <= w_out;
            end
            if (w_adv & r_vld_pipe[2] & w_r_ovf) r_ovf <= 1'b1;
            else if (ovf_clr_i)                  r_ovf <= 1'b0;
        end
    end

    // DRAIN exits on the edge that empties the pipeline, so busy_o drops right after the last beat.
    always_ff @(posedge clk_adc_125mhz or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (en_i) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b1;
                end
                ST_RUN: if (!en_i) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (en_i) begin
                        r_state <= ST_RUN;
                    end else if (w_vld_nxt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mix_m_vld  = r_vld_pipe[3];
    assign mix_m_data = r_out;
    assign ovf_o      = r_ovf;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_rb_osc_am_mixer.sv
// Bench for rb_osc_am_mixer: directed vector table, drain/reset sequences, and randomized
// traffic scored against an arithmetic model of car * (ofs + gain*mod).
module tb_rb_osc_am_mixer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, car_vld = 1'b0, mod_vld = 1'b0, mix_rdy = 1'b0, ovf_clr = 1'b0;
    logic [15:0] car_d = '0, mod_d = '0, gain = '0, ofs = '0;
    logic        car_rdy, mod_rdy, mix_vld, ovf, busy;
    logic [15:0] mix_d;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] exp_q[$];
    bit          prev_stall = 0;
    logic [15:0] prev_d = '0;

    typedef struct {
        logic [15:0] car, mod, gain, ofs, exp_d;
        logic        exp_ov;
    } vec_t;
    vec_t vt[5];

    rb_osc_am_mixer #(.DW(16), .GW(16)) dut (
        .clk_adc_125mhz(clk), .adc_rst_i(rst), .en_i(en),
        .car_s_vld(car_vld), .car_s_data(car_d), .car_s_rdy(car_rdy),
        .mod_s_vld(mod_vld), .mod_s_data(mod_d), .mod_s_rdy(mod_rdy),
        .gain_i(gain), .ofs_i(ofs),
        .mix_m_vld(mix_vld), .mix_m_data(mix_d), .mix_m_rdy(mix_rdy),
        .ovf_o(ovf), .ovf_clr_i(ovf_clr), .busy_o(busy)
    );

    always #4 clk = ~clk;

    // Envelope and product from plain integer arithmetic (>>> on longint is floor division).
    function automatic logic [15:0] ref_mix(input logic [15:0] c, input logic [15:0] m,
                                            input logic [15:0] g, input logic [15:0] o);
        longint env, r;
        env = longint'(o) + ((longint'(g) * longint'($signed(m))) >>> 16);
        r   = (longint'($signed(c)) * env) >>> 15;
`ifdef RB_AM_MIXER_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) chk("hold_data", {15'd0, mix_vld, mix_d}, {15'd0, 1'b1, prev_d});
            if (mix_vld && !mix_rdy) chk("stall_rdy", {car_rdy, mod_rdy}, 2'b00);
            chk("join_sync", car_vld & car_rdy, mod_vld & mod_rdy);
            if (car_vld && car_rdy && mod_vld && mod_rdy)
                exp_q.push_back(ref_mix(car_d, mod_d, gain, ofs));
            if (mix_vld && mix_rdy) begin
                if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                else chk("stream_data", mix_d, exp_q.pop_front());
            end
            prev_stall = mix_vld && !mix_rdy;
            prev_d     = mix_d;
        end
    end

    task automatic send_check(input vec_t v, input string nm);
        int lat;
        car_d = v.car; mod_d = v.mod; gain = v.gain; ofs = v.ofs;
        car_vld = 1'b1; mod_vld = 1'b1;
        @(negedge clk);
        chk({nm, "_accept"}, car_rdy & mod_rdy, 1);
        @(posedge clk); #1;
        car_vld = 1'b0; mod_vld = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!mix_vld && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_data"}, mix_d, v.exp_d);
        chk({nm, "_ovf"}, ovf, v.exp_ov);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ramp, got, k;
        bit hs;
        vt[0] = '{16'h4000, 16'h1234, 16'h0000, 16'h8000, 16'h4000, 1'b0};
        vt[1] = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h4000, 16'h7FFE, 1'b0};
        vt[2] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h4000, 16'h8001, 1'b0};
`ifdef RB_AM_MIXER_SAT_EN
        vt[3] = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 1'b1};
        vt[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8000, 1'b1};
`else
        vt[3] = '{16'h7FFF, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h7FFA, 1'b1};
        vt[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8003, 1'b1};
`endif

        // Reset with inputs active: nothing may be offered or produced.
        en = 1'b1; car_vld = 1'b1; mod_vld = 1'b1; mix_rdy = 1'b1;
        #1 rst = 1'b1;
        #10;
        chk("rst_vld", mix_vld, 0);
        chk("rst_data", mix_d, 0);
        chk("rst_rdy", {car_rdy, mod_rdy}, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        car_vld = 1'b0; mod_vld = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("run_busy", busy, 1);

        // Directed vectors; the last one holds ovf_clr high so the set must win.
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) ovf_clr = 1'b1;
            send_check(vt[i], $sformatf("vec%0d", i));
            tick();
            ovf_clr = 1'b1;
            tick();
            ovf_clr = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_ovf_clr", i), ovf, 0);
        end

        // Continuous ramp with a 5-cycle downstream stall.
        tick();
        gain = 16'h0000; ofs = 16'h8000; mod_d = 16'h1111;
        ramp = 0; car_d = 16'(ramp); car_vld = 1'b1; mod_vld = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            hs = car_rdy & car_vld;
            @(posedge clk); #1;
            if (hs) begin
                ramp++;
                car_d = 16'(ramp);
            end
            mix_rdy = !(c >= 12 && c < 17);
        end
        car_vld = 1'b0; mod_vld = 1'b0; mix_rdy = 1'b1;
        for (int j = 0; j < 50 && exp_q.size() != 0; j++) @(negedge clk);
        chk("ramp_drained", exp_q.size(), 0);
        chk("ramp_progress", ramp > 30, 1);

        // Modulator absent: no beat may be consumed.
        tick();
        car_vld = 1'b1; mod_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("join_car_rdy", car_rdy, 0);
            chk("join_mod_rdy", mod_rdy, 1);
            chk("join_no_out", mix_vld, 0);
        end

        // Three beats in flight, then enable drops.
        tick();
        mod_vld = 1'b1;
        got = 0;
        for (int j = 0; j < 20 && got < 3; j++) begin
            @(negedge clk);
            if (car_rdy) got++;
            @(posedge clk); #1;
            car_d = car_d + 16'd1;
        end
        chk("drain_fill", got, 3);
        en = 1'b0; car_vld = 1'b0; mod_vld = 1'b0;
        got = 0; k = 0;
        while (got < 3 && k < 20) begin
            @(negedge clk);
            if (k > 0) chk("drain_no_accept", car_rdy | mod_rdy, 0);
            if (mix_vld && mix_rdy) got++;
            if (got < 3) begin
                @(posedge clk); #1;
                if (k == 0) begin car_vld = 1'b1; mod_vld = 1'b1; end
            end
            k++;
        end
        chk("drain_count", got, 3);
        chk("drain_busy_last", busy, 1);
        @(negedge clk);
        chk("drain_busy_off", busy, 0);
        repeat (4) begin
            @(negedge clk);
            chk("drain_no_extra", mix_vld | car_rdy, 0);
        end
        tick();
        car_vld = 1'b0; mod_vld = 1'b0;

        // Asynchronous reset with beats in flight and ovf set.
        en = 1'b1; mix_rdy = 1'b0;
        tick();
        car_d = vt[3].car; mod_d = vt[3].mod; gain = vt[3].gain; ofs = vt[3].ofs;
        car_vld = 1'b1; mod_vld = 1'b1;
        repeat (6) tick();
        car_vld = 1'b0; mod_vld = 1'b0;
        @(negedge clk);
        chk("prerst_ovf", ovf, 1);
        chk("prerst_vld", mix_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", mix_vld, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0; mix_rdy = 1'b1;
        tick();
        tick();
        send_check(vt[0], "post_rst");

        // Randomized traffic, including enable toggles through DRAIN.
        for (int c = 0; c < 3000; c++) begin
            car_vld = ($urandom_range(0, 3) != 0);
            mod_vld = ($urandom_range(0, 3) != 0);
            car_d   = 16'($urandom);
            mod_d   = 16'($urandom);
            gain    = 16'($urandom);
            ofs     = 16'($urandom);
            mix_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) en = !en;
            tick();
        end
        en = 1'b1; car_vld = 1'b0; mod_vld = 1'b0; mix_rdy = 1'b1;
        for (int j = 0; j < 50 && exp_q.size() != 0; j++) @(negedge clk);
        chk("rand_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
